// File: rtl/nios_lights_cpu_jtag_monitor_ram.sv
// System-clock side of the Nios II JTAG debug monitor: executes JTAG ocimem
// commands and CPU slave accesses against a shared synchronous-read monitor RAM.
module nios_lights_cpu_jtag_monitor_ram #(
  parameter int RAM_AW = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [RAM_AW-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_JTAG_RD = 2'd1, ST_CPU_RD = 2'd2} state_e;
  typedef enum logic [1:0] {CMD_A = 2'd0, CMD_B = 2'd1, CMD_RD = 2'd2} cmd_e;

  localparam logic [RAM_AW-1:0] AW_ONE = {{(RAM_AW-1){1'b0}}, 1'b1};

  state_e              state_q;
  cmd_e                pend_cmd_q;
  logic                pend_vld_q;
  logic [33:0]         pend_jdo_q;
  logic                jrd_inc_q;
  logic [RAM_AW-1:0]   mon_a_q;
  logic [31:0]         mon_d_q;
  logic                ready_q;
  logic                error_q;
  logic [31:0]         mem_q [2**RAM_AW];
  logic [31:0]         ram_q;

  cmd_e                live_cmd_s;
  cmd_e                exec_cmd_s;
  logic [33:0]         exec_jdo_s;
  logic                live_vld_s, multi_s, idle_s, exec_vld_s;
  logic                latch_s, drop_s, cpu_wr_grant_s, cpu_rd_grant_s;
  logic [RAM_AW-1:0]   exec_addr_s;
  logic [31:0]         exec_data_s;
  logic                exec_rd_s, exec_clr_s;
  logic                ram_we_s;
  logic [RAM_AW-1:0]   ram_addr_s;
  logic [31:0]         ram_wdata_s;
  logic                unused_jdo_s;

  assign unused_jdo_s = ^{jdo[37:36], jdo[1:0]};

  assign live_vld_s = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign multi_s    = (take_action_ocimem_a & take_action_ocimem_b) |
                      (take_action_ocimem_a & take_no_action_ocimem_a) |
                      (take_action_ocimem_b & take_no_action_ocimem_a);
  assign idle_s     = (state_q == ST_IDLE);
  assign exec_vld_s = idle_s & (pend_vld_q | live_vld_s);
  // A live strobe is parked when busy or when the pending slot has the turn;
  // it is lost only if the slot is full and cannot drain this cycle.
  assign latch_s    = live_vld_s & (~idle_s | pend_vld_q);
  assign drop_s     = live_vld_s & ~idle_s & pend_vld_q;

  assign cpu_wr_grant_s = idle_s & ~exec_vld_s & cpu_write;
  assign cpu_rd_grant_s = idle_s & ~exec_vld_s & ~cpu_write & cpu_read;

  // Select the live command by strobe priority and the command to execute.
  always_comb begin
    if (take_action_ocimem_a) begin
      live_cmd_s = CMD_A;
    end else if (take_action_ocimem_b) begin
      live_cmd_s = CMD_B;
    end else begin
      live_cmd_s = CMD_RD;
    end
    if (pend_vld_q) begin
      exec_cmd_s = pend_cmd_q;
      exec_jdo_s = pend_jdo_q;
    end else begin
      exec_cmd_s = live_cmd_s;
      exec_jdo_s = jdo[35:2];
    end
  end

  // jdo[35:2] is held as bits [33:0]: addr [7:0], data [32:1], clear [32], read [33].
  assign exec_addr_s = exec_jdo_s[RAM_AW-1:0];
  assign exec_data_s = exec_jdo_s[32:1];
  assign exec_clr_s  = exec_jdo_s[32];
  assign exec_rd_s   = exec_jdo_s[33];

  // Single RAM port shared by JTAG execution and granted CPU accesses.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_addr_s  = mon_a_q;
    ram_wdata_s = cpu_writedata;
    if (exec_vld_s) begin
      case (exec_cmd_s)
        CMD_A: ram_addr_s = exec_addr_s;
        CMD_B: begin
          ram_we_s    = 1'b1;
          ram_wdata_s = exec_data_s;
        end
        default: ram_addr_s = mon_a_q;
      endcase
    end else if (cpu_wr_grant_s) begin
      ram_we_s   = 1'b1;
      ram_addr_s = cpu_address;
    end else if (cpu_rd_grant_s) begin
      ram_addr_s = cpu_address;
    end else begin
      ram_addr_s = mon_a_q;
    end
  end

  // Monitor RAM: synchronous read, contents not reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      mem_q[ram_addr_s] <= ram_wdata_s;
    end
    ram_q <= mem_q[ram_addr_s];
  end

  // Control FSM, pending slot and monitor registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pend_vld_q <= 1'b0;
      pend_cmd_q <= CMD_A;
      pend_jdo_q <= 34'd0;
      jrd_inc_q  <= 1'b0;
      mon_a_q    <= {RAM_AW{1'b0}};
      mon_d_q    <= 32'd0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      if (latch_s && !drop_s) begin
        pend_vld_q <= 1'b1;
        pend_cmd_q <= live_cmd_s;
        pend_jdo_q <= jdo[35:2];
      end else if (exec_vld_s && pend_vld_q) begin
        pend_vld_q <= 1'b0;
      end

      if (multi_s || drop_s) begin
        error_q <= 1'b1;
      end else if (exec_vld_s && exec_cmd_s == CMD_A && exec_clr_s) begin
        error_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (exec_vld_s) begin
            case (exec_cmd_s)
              CMD_A: begin
                mon_a_q   <= exec_addr_s;
                jrd_inc_q <= 1'b0;
                ready_q   <= ~exec_rd_s;
                if (exec_rd_s) begin
                  state_q <= ST_JTAG_RD;
                end
              end
              CMD_B: begin
                mon_d_q <= exec_data_s;
                mon_a_q <= mon_a_q + AW_ONE;
                ready_q <= 1'b1;
              end
              default: begin
                jrd_inc_q <= 1'b1;
                ready_q   <= 1'b0;
                state_q   <= ST_JTAG_RD;
              end
            endcase
          end else if (cpu_rd_grant_s) begin
            state_q <= ST_CPU_RD;
          end
        end
        ST_JTAG_RD: begin
          mon_d_q <= ram_q;
          // Ready only reflects completion when nothing is still queued behind.
          ready_q <= ~pend_vld_q;
          if (jrd_inc_q) begin
            mon_a_q <= mon_a_q + AW_ONE;
          end
          state_q <= ST_IDLE;
        end
        ST_CPU_RD: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase

      if (latch_s && !drop_s) begin
        ready_q <= 1'b0;
      end
    end
  end

  assign cpu_readdata    = (state_q == ST_CPU_RD) ? ram_q : 32'd0;
  assign cpu_waitrequest = (cpu_read | cpu_write) & ~(cpu_wr_grant_s | (state_q == ST_CPU_RD));
  assign MonDReg         = mon_d_q;
  assign monitor_ready   = ready_q;
  assign monitor_error   = error_q;

endmodule
